// File: rtl/cmd_proto_pkg.sv
// Shared definitions for the inter-board command protocol.
// Both command_sender and the switch-board command responder use this package.
package cmd_proto_pkg;

    localparam logic [7:0] CMD_HDR     = 8'hA5;
    localparam logic [7:0] RSP_HDR     = 8'h5A;
    localparam logic [7:0] ERR_TIMEOUT = 8'hFF;
    localparam logic [7:0] ERR_CHKSUM  = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        HUNT,
        STAT,
        CHK,
        FIN
    } cmd_sender_state_t;

    // Frame checksums are a plain byte-wise XOR; pass 8'h00 for unused operands.
    function automatic logic [7:0] xorChecksum(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] c);
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Response timeout counter: cleared while idle/sending, counts while enabled.
// expired_o rises during the TIMEOUT_CYCLES-th enabled cycle and stays up until cleared.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturate so a timeout that is deferred by a pop is still seen next cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q >= LAST);

endmodule

// File: rtl/command_sender.sv
// Initiator side of the command protocol: sends A5/cmd/arg/chk, then parses 5A/status/chk.
// Define CMD_SENDER_RETRY_EN to re-send up to MAX_RETRY times after a timeout or bad checksum.
module command_sender
    import cmd_proto_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int COUNTER_W      = 5,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [7:0]           req_cmd_i,
    input  logic [7:0]           req_arg_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 ok_o,
    output logic [7:0]           resp_status_o,
    output logic                 tf_push_o,
    output logic [7:0]           tdr_o,
    input  logic [COUNTER_W-1:0] tf_count_i,
    output logic                 rf_pop_o,
    input  logic [7:0]           rdr_i,
    input  logic [COUNTER_W-1:0] rf_counter_i
);

    localparam logic [COUNTER_W-1:0] DEPTH_CNT = COUNTER_W'(FIFO_DEPTH);

    cmd_sender_state_t state_q, state_d;
    logic [1:0] byteIdx_q, byteIdx_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] status_q, status_d;
    logic       ok_q, ok_d;
    logic [7:0] respStatus_q, respStatus_d;

    logic       push;
    logic       pop;
    logic [7:0] txByte;
    logic       errValid;
    logic [7:0] errCode;
    logic       timerEn;
    logic       expired;
    logic       rxAvail;
    logic       txSpace;

`ifdef CMD_SENDER_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retryCnt_q, retryCnt_d;
`else
    logic unusedRetryCfg;
    assign unusedRetryCfg = (MAX_RETRY != 0);
`endif

    assign rxAvail = (rf_counter_i != '0);
    assign txSpace = (tf_count_i < DEPTH_CNT);
    assign timerEn = (state_q == HUNT) || (state_q == STAT) || (state_q == CHK);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!timerEn),
        .enable_i (timerEn),
        .expired_o(expired)
    );

    always_comb begin
        unique case (byteIdx_q)
            2'd0:    txByte = CMD_HDR;
            2'd1:    txByte = cmd_q;
            2'd2:    txByte = arg_q;
            default: txByte = xorChecksum(CMD_HDR, cmd_q, arg_q);
        endcase
    end

    // A pop in the same cycle as expiry wins; the timeout is only acted on when no byte arrived.
    always_comb begin
        state_d      = state_q;
        byteIdx_d    = byteIdx_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        status_d     = status_q;
        ok_d         = ok_q;
        respStatus_d = respStatus_q;
        push         = 1'b0;
        pop          = 1'b0;
        errValid     = 1'b0;
        errCode      = 8'h00;
`ifdef CMD_SENDER_RETRY_EN
        retryCnt_d   = retryCnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                pop = rxAvail;
                if (req_i) begin
                    cmd_d        = req_cmd_i;
                    arg_d        = req_arg_i;
                    ok_d         = 1'b0;
                    respStatus_d = 8'h00;
                    byteIdx_d    = 2'd0;
                    state_d      = SEND;
`ifdef CMD_SENDER_RETRY_EN
                    retryCnt_d   = '0;
`endif
                end
            end
            SEND: begin
                if (txSpace) begin
                    push = 1'b1;
                    if (byteIdx_q == 2'd3) begin
                        byteIdx_d = 2'd0;
                        state_d   = HUNT;
                    end else begin
                        byteIdx_d = byteIdx_q + 2'd1;
                    end
                end
            end
            HUNT: begin
                if (rxAvail) begin
                    pop = 1'b1;
                    if (rdr_i == RSP_HDR) begin
                        state_d = STAT;
                    end
                end else if (expired) begin
                    errValid = 1'b1;
                    errCode  = ERR_TIMEOUT;
                end
            end
            STAT: begin
                if (rxAvail) begin
                    pop      = 1'b1;
                    status_d = rdr_i;
                    state_d  = CHK;
                end else if (expired) begin
                    errValid = 1'b1;
                    errCode  = ERR_TIMEOUT;
                end
            end
            CHK: begin
                if (rxAvail) begin
                    pop = 1'b1;
                    if (rdr_i == xorChecksum(RSP_HDR, status_q, 8'h00)) begin
                        ok_d         = 1'b1;
                        respStatus_d = status_q;
                        state_d      = FIN;
                    end else begin
                        errValid = 1'b1;
                        errCode  = ERR_CHKSUM;
                    end
                end else if (expired) begin
                    errValid = 1'b1;
                    errCode  = ERR_TIMEOUT;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (errValid) begin
`ifdef CMD_SENDER_RETRY_EN
            if (retryCnt_q < RETRY_W'(MAX_RETRY)) begin
                retryCnt_d = retryCnt_q + 1'b1;
                byteIdx_d  = 2'd0;
                state_d    = SEND;
            end else begin
                ok_d         = 1'b0;
                respStatus_d = errCode;
                state_d      = FIN;
            end
`else
            ok_d         = 1'b0;
            respStatus_d = errCode;
            state_d      = FIN;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            byteIdx_q    <= 2'd0;
            cmd_q        <= 8'h00;
            arg_q        <= 8'h00;
            status_q     <= 8'h00;
            ok_q         <= 1'b0;
            respStatus_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            byteIdx_q    <= byteIdx_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            status_q     <= status_d;
            ok_q         <= ok_d;
            respStatus_q <= respStatus_d;
        end
    end

`ifdef CMD_SENDER_RETRY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retryCnt_q <= '0;
        end else begin
            retryCnt_q <= retryCnt_d;
        end
    end
`endif

    // Strobes are masked during reset so an aborted frame stops immediately.
    assign tf_push_o     = push && !rst_i;
    assign rf_pop_o      = pop && !rst_i;
    assign tdr_o         = tf_push_o ? txByte : 8'h00;
    assign ready_o       = (state_q == IDLE);
    assign done_o        = (state_q == FIN);
    assign ok_o          = ok_q;
    assign resp_status_o = respStatus_q;

endmodule

// File: doc/command_sender.md
# command_sender

Initiator end of the inter-board command protocol. It frames a one-byte command and a one-byte argument into a 4-byte packet, pushes the packet into a UART TX FIFO, then parses a 3-byte response from the UART RX FIFO. A timeout, and optionally retries, cover a silent peer. It sits beside a UART core in a supervisor design and drives the switch board's `command` responder.

## Interface
- `FIFO_DEPTH`, 16: UART TX FIFO depth in bytes.
- `COUNTER_W`, 5: FIFO counter width; equals `UART_FIFO_COUNTER_W`.
- `TIMEOUT_CYCLES`, 100000: clk cycles allowed for a full response.
- `MAX_RETRY`, 2: re-sends after the first attempt.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: start request; sampled only while `ready`=1.
- `req_cmd` in 8: command byte, captured when `req` is accepted.
- `req_arg` in 8: argument byte, captured when `req` is accepted.
- `ready` out 1: idle, can accept `req`.
- `done` out 1: one-cycle completion pulse.
- `ok` out 1: result flag, valid with `done` and held until the next accept.
- `resp_status` out 8: response status byte or error code; held like `ok`.
- `tf_push` out 1: TX FIFO push strobe.
- `tdr` out 8: TX byte, valid while `tf_push`=1.
- `tf_count` in COUNTER_W: TX FIFO fill level.
- `rf_pop` out 1: RX FIFO pop strobe.
- `rdr` in 8: head of RX FIFO, sampled in the same cycle as `rf_pop`.
- `rf_counter` in COUNTER_W: RX FIFO fill level.

## Operation
- Request frame: `0xA5`, `cmd`, `arg`, `chk`, where `chk` = `0xA5`^`cmd`^`arg`.
- Response frame: `0x5A`, `status`, `chk`, where `chk` = `0x5A`^`status`.
- All checksums are 8-bit XOR; no carries.
- States:
  - IDLE: `ready`=1. Drains stale RX bytes by popping whenever `rf_counter`≠0. On `req`, latches `cmd`/`arg`, clears the retry count, goes to SEND.
  - SEND: byte index 0..3. Pushes one byte per cycle only when `tf_count` < FIFO_DEPTH; otherwise stalls with the index held. After index 3 it clears the timer and goes to HUNT.
  - HUNT: pops when `rf_counter`≠0. Discards bytes other than `0x5A`. On `0x5A`, goes to STAT.
  - STAT: pops one byte and latches it as status, then goes to CHK.
  - CHK: pops one byte. Match gives `ok`=1, `resp_status`=status. Mismatch raises error code `0xFE`.
  - FIN: `done`=1 for one cycle, then IDLE.
- The timer runs in HUNT, STAT and CHK. Reaching TIMEOUT_CYCLES raises error code `0xFF`.
- On error:
  - If retries remain, the retry count increments and the block returns to SEND at index 0 with the same `cmd`/`arg`.
  - Otherwise it goes to FIN with `ok`=0 and `resp_status`=error code.
- Simultaneous events:
  - Timeout in the same cycle as a pop: the popped byte is processed and the timeout is ignored that cycle.
  - `req` while `ready`=0 is ignored.
- `rf_pop` and `tf_push` are never asserted in the same cycle.

## Timing
- `rst` values: `ready`=1; `done`, `ok`, `tf_push`, `rf_pop`=0; `resp_status`, `tdr`=0x00. State is IDLE, timer and retry count are 0.
- `rst` asserted mid-frame: next cycle is IDLE with no further push or pop. Partial TX bytes already in the FIFO are not recalled.
- `req` accepted in cycle N: `ready`=0 in N+1, first `tf_push` in N+1 if space. With no stalls the four pushes occupy N+1..N+4.
- Maximum pop rate is one per cycle.
- `done` asserts the cycle after the check byte is popped, or the cycle after the final error.
- `ready` returns to 1 in the cycle after `done`.
- Timeout latency is exactly TIMEOUT_CYCLES cycles after the HUNT entry edge.

## Configuration
- `CMD_SENDER_RETRY_EN` defined: retries as above, up to MAX_RETRY re-sends.
- Undefined: the retry counter and logic are removed; the first error goes straight to FIN. MAX_RETRY is ignored.

## Structure
- Shared package `cmd_proto_pkg`:
  - `CMD_HDR` (`0xA5`), `RSP_HDR` (`0x5A`).
  - `ERR_TIMEOUT` (`0xFF`), `ERR_CHKSUM` (`0xFE`).
  - State enum `cmd_sender_state_t`.
  - Checksum function.
  - The package is reused by `command`.
- One sub-module, `cmd_timeout_timer`: load/clear, enable, `expired` output, width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Nominal exchange:
  - Stimulus: `req` with cmd=0x31, arg=0x02.
  - Required: TX bytes A5 31 02 96 in four consecutive cycles.
  - Then inject 5A 00 5A: `done` with `ok`=1, `resp_status`=0x00.
- Garbage before header:
  - Stimulus: RX bytes 00 FF 5A 03 59.
  - Required: leading bytes discarded, `ok`=1, `resp_status`=0x03.
- Checksum error, with the macro undefined:
  - Stimulus: RX bytes 5A 01 00.
  - Required: `ok`=0, `resp_status`=0xFE, one frame sent.
- Timeout with retry:
  - Stimulus: TIMEOUT_CYCLES=100, MAX_RETRY=2, macro defined, no response.
  - Required: three identical frames, each sent 100 cycles after the previous HUNT entry, then `ok`=0, `resp_status`=0xFF.
- Full TX FIFO:
  - Stimulus: `tf_count`=16 for 5 cycles after accept.
  - Required: no `tf_push` during those cycles, then four pushes. Frame bytes are unchanged.
- Reset mid-SEND:
  - Stimulus: `rst` asserted after 2 pushes.
  - Required: the cycle after `rst`, `ready`=1 and no further pushes. A new `req` sends a full frame.
